// File: rtl/lsu_misalign_seq_pkg.sv
// Shared definitions for the load/store misalignment sequencer:
// funct3 encodings, FSM state type, access-size decode and default memory size.
package lsu_pkg;

    localparam int unsigned DEFAULT_MEM_SIZE = 4096;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } lsu_state_e;

    // Access size in bytes; 0 marks a funct3 that is illegal for this direction.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3, input logic we);
        logic [2:0] sz;
        case (funct3)
            F3_B:    sz = 3'd1;
            F3_H:    sz = 3'd2;
            F3_W:    sz = 3'd4;
            F3_BU:   sz = we ? 3'd0 : 3'd1;
            F3_HU:   sz = we ? 3'd0 : 3'd2;
            default: sz = 3'd0;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_misalign_seq_if.sv
// Request/response and data-memory bus of the load/store sequencer.
// slave: the sequencer itself; master: execute stage plus data memory side.
interface lsu_misalign_seq_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output stall, rsp_valid, rsp_rdata, fault,
               mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, fault,
               mem_read, mem_write, mem_funct3, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_misalign_seq_align_check.sv
// Combinational access classification: size, misalignment and fault.
module lsu_align_check
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic        we,
    output logic [2:0]  size,
    output logic        misaligned,
    output logic        fault
);

    logic [32:0] last_byte;

    // Decode size, check alignment and bound the last touched byte without wrap.
    always_comb begin
        size       = lsu_size(funct3, we);
        misaligned = ((size == 3'd2) && addr[0]) ||
                     ((size == 3'd4) && (addr[1:0] != 2'b00));
        last_byte  = {1'b0, addr} + {30'b0, size} - 33'd1;
        fault      = (size == 3'd0) ||
                     (last_byte >= 33'(MEM_SIZE)) ||
                     (misaligned && !SPLIT_EN);
    end

endmodule

// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer in front of the byte-addressed data memory.
// Aligned accesses pass straight through; misaligned halfword/word accesses
// are replayed as byte accesses while the core is stalled.
module lsu_misalign_seq
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter bit          SPLIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_misalign_seq_if.slave  bus
);

    lsu_state_e  state;
    logic [1:0]  byte_idx;
    logic [23:0] lbuf;

    logic [2:0]  size;
    logic        misaligned;
    logic        chk_fault;
    logic        last;
    logic [7:0]  wbyte;
    logic [31:0] split_word;

    lsu_align_check #(
        .MEM_SIZE (MEM_SIZE),
        .SPLIT_EN (SPLIT_EN)
    ) u_align_check (
        .funct3     (bus.req_funct3),
        .addr       (bus.req_addr),
        .we         (bus.req_we),
        .size       (size),
        .misaligned (misaligned),
        .fault      (chk_fault)
    );

    // Current store byte, last-byte detection and assembled split-load result.
    always_comb begin
        last = ({1'b0, byte_idx} == (size - 3'd1));
        case (byte_idx)
            2'd0:    wbyte = bus.req_wdata[7:0];
            2'd1:    wbyte = bus.req_wdata[15:8];
            2'd2:    wbyte = bus.req_wdata[23:16];
            default: wbyte = bus.req_wdata[31:24];
        endcase
        if (size == 3'd2) begin
            if (bus.req_funct3 == F3_H)
                split_word = {{16{bus.mem_rdata[7]}}, bus.mem_rdata[7:0], lbuf[7:0]};
            else
                split_word = {16'b0, bus.mem_rdata[7:0], lbuf[7:0]};
        end else begin
            split_word = {bus.mem_rdata[7:0], lbuf};
        end
    end

    // Memory strobes and response; everything held at 0 while in reset.
    always_comb begin
        bus.stall      = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = '0;
        bus.fault      = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_funct3 = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        if (rst_n && bus.req_valid) begin
            if (state == IDLE && chk_fault) begin
                bus.fault     = 1'b1;
                bus.rsp_valid = 1'b1;
            end else if (state == IDLE && !misaligned) begin
                bus.mem_read   = !bus.req_we;
                bus.mem_write  = bus.req_we;
                bus.mem_funct3 = bus.req_funct3;
                bus.mem_addr   = bus.req_addr;
                bus.mem_wdata  = bus.req_wdata;
                bus.rsp_valid  = 1'b1;
                bus.rsp_rdata  = bus.req_we ? '0 : bus.mem_rdata;
            end else begin
                // byte_idx is 0 in IDLE, so the first split byte shares this path
                bus.mem_read   = !bus.req_we;
                bus.mem_write  = bus.req_we;
                bus.mem_funct3 = bus.req_we ? F3_B : F3_BU;
                bus.mem_addr   = bus.req_addr + {30'b0, byte_idx};
                bus.mem_wdata  = {24'b0, wbyte};
                if (state == SPLIT && last) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = bus.req_we ? '0 : split_word;
                end else begin
                    bus.stall = 1'b1;
                end
            end
        end
    end

    // Split sequencing: collect load bytes and step through the byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            lbuf     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && !chk_fault && misaligned) begin
                        lbuf[7:0] <= bus.mem_rdata[7:0];
                        byte_idx  <= 2'd1;
                        state     <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (!bus.req_valid || last) begin
                        byte_idx <= '0;
                        state    <= IDLE;
                    end else begin
                        case (byte_idx)
                            2'd1:    lbuf[15:8]  <= bus.mem_rdata[7:0];
                            2'd2:    lbuf[23:16] <= bus.mem_rdata[7:0];
                            default: ;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Directed bench for lsu_misalign_seq with a byte-array data memory model.
module tb_lsu_misalign_seq;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [0:4095];

    lsu_misalign_seq_if bus ();
    lsu_misalign_seq_if bus_ns ();

    lsu_misalign_seq #(
        .MEM_SIZE (4096),
        .SPLIT_EN (1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    lsu_misalign_seq #(
        .MEM_SIZE (4096),
        .SPLIT_EN (1'b0)
    ) u_dut_ns (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ns)
    );

    always #5 clk = ~clk;

    // Combinational memory read with load extension by funct3.
    always_comb begin
        logic [11:0] a;
        a = bus.mem_addr[11:0];
        bus.mem_rdata = '0;
        if (bus.mem_read) begin
            case (bus.mem_funct3)
                3'b000:  bus.mem_rdata = {{24{mem[a][7]}}, mem[a]};
                3'b100:  bus.mem_rdata = {24'b0, mem[a]};
                3'b001:  bus.mem_rdata = {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
                3'b101:  bus.mem_rdata = {16'b0, mem[a+12'd1], mem[a]};
                3'b010:  bus.mem_rdata = {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
                default: bus.mem_rdata = '0;
            endcase
        end
    end

    // Memory write on the rising edge.
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_addr[11:0]] <= bus.mem_wdata[7:0];
            if (bus.mem_funct3 == 3'b001 || bus.mem_funct3 == 3'b010)
                mem[bus.mem_addr[11:0] + 12'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_funct3 == 3'b010) begin
                mem[bus.mem_addr[11:0] + 12'd2] <= bus.mem_wdata[23:16];
                mem[bus.mem_addr[11:0] + 12'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"},      32'(bus.stall),      32'd0);
        chk({tag, ".rsp_valid"},  32'(bus.rsp_valid),  32'd0);
        chk({tag, ".rsp_rdata"},  bus.rsp_rdata,       32'd0);
        chk({tag, ".fault"},      32'(bus.fault),      32'd0);
        chk({tag, ".mem_read"},   32'(bus.mem_read),   32'd0);
        chk({tag, ".mem_write"},  32'(bus.mem_write),  32'd0);
        chk({tag, ".mem_funct3"}, 32'(bus.mem_funct3), 32'd0);
        chk({tag, ".mem_addr"},   bus.mem_addr,        32'd0);
        chk({tag, ".mem_wdata"},  bus.mem_wdata,       32'd0);
    endtask

    // Check one cycle at the falling edge, then move just past the next rising edge.
    task automatic cyc(input string tag, input bit st, input bit rv, input bit flt,
                       input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd);
        @(negedge clk);
        chk({tag, ".stall"},     32'(bus.stall),     32'(st));
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
        chk({tag, ".fault"},     32'(bus.fault),     32'(flt));
        chk({tag, ".mem_read"},  32'(bus.mem_read),  32'(mr));
        chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(mw));
        if (mr || mw) begin
            chk({tag, ".mem_funct3"}, 32'(bus.mem_funct3), 32'(f3));
            chk({tag, ".mem_addr"},   bus.mem_addr,        addr);
        end
        if (mw) begin
            if (f3 == F3_B) chk({tag, ".wbyte"}, 32'(bus.mem_wdata[7:0]), 32'(wd[7:0]));
            else            chk({tag, ".wdata"}, bus.mem_wdata, wd);
        end
        if (rv) chk({tag, ".rsp_rdata"}, bus.rsp_rdata, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        bus_ns.mem_rdata  = '0;
        bus_ns.req_valid  = 1'b0;
        bus_ns.req_we     = 1'b0;
        bus_ns.req_funct3 = '0;
        bus_ns.req_addr   = '0;
        bus_ns.req_wdata  = '0;
        rst_n = 1'b0;
        drive(1'b0, F3_W, 32'h100, 32'h0);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_all_zero("idle");
        @(posedge clk);
        #1;

        // 1: aligned word store and load
        drive(1'b1, F3_W, 32'h100, 32'hDEADBEEF);
        cyc("sw_al", 0, 1, 0, 0, 1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0);
        drive(1'b0, F3_W, 32'h100, 32'h0);
        cyc("lw_al", 0, 1, 0, 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF);

        // 2: misaligned word store then load
        drive(1'b1, F3_W, 32'h201, 32'h11223344);
        cyc("sw_m0", 1, 0, 0, 0, 1, F3_B, 32'h201, 32'h44, 32'h0);
        cyc("sw_m1", 1, 0, 0, 0, 1, F3_B, 32'h202, 32'h33, 32'h0);
        cyc("sw_m2", 1, 0, 0, 0, 1, F3_B, 32'h203, 32'h22, 32'h0);
        cyc("sw_m3", 0, 1, 0, 0, 1, F3_B, 32'h204, 32'h11, 32'h0);
        chk("mem201", 32'(mem[12'h201]), 32'h44);
        chk("mem204", 32'(mem[12'h204]), 32'h11);
        drive(1'b0, F3_W, 32'h201, 32'h0);
        cyc("lw_m0", 1, 0, 0, 1, 0, F3_BU, 32'h201, 32'h0, 32'h0);
        cyc("lw_m1", 1, 0, 0, 1, 0, F3_BU, 32'h202, 32'h0, 32'h0);
        cyc("lw_m2", 1, 0, 0, 1, 0, F3_BU, 32'h203, 32'h0, 32'h0);
        cyc("lw_m3", 0, 1, 0, 1, 0, F3_BU, 32'h204, 32'h0, 32'h11223344);

        // 3: misaligned halfword across a 256-byte boundary, signed and unsigned reload
        drive(1'b1, F3_H, 32'h2FF, 32'h000080FF);
        cyc("sh_m0", 1, 0, 0, 0, 1, F3_B, 32'h2FF, 32'hFF, 32'h0);
        cyc("sh_m1", 0, 1, 0, 0, 1, F3_B, 32'h300, 32'h80, 32'h0);
        drive(1'b0, F3_H, 32'h2FF, 32'h0);
        cyc("lh_m0", 1, 0, 0, 1, 0, F3_BU, 32'h2FF, 32'h0, 32'h0);
        cyc("lh_m1", 0, 1, 0, 1, 0, F3_BU, 32'h300, 32'h0, 32'hFFFF80FF);
        drive(1'b0, F3_HU, 32'h2FF, 32'h0);
        cyc("lhu_m0", 1, 0, 0, 1, 0, F3_BU, 32'h2FF, 32'h0, 32'h0);
        cyc("lhu_m1", 0, 1, 0, 1, 0, F3_BU, 32'h300, 32'h0, 32'h000080FF);

        // 4: bounds, illegal funct3, no-split instance
        drive(1'b0, F3_W, 32'hFFE, 32'h0);
        cyc("lw_oob", 0, 1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        drive(1'b1, F3_B, 32'hFFF, 32'h0000005A);
        cyc("sb_top", 0, 1, 0, 0, 1, F3_B, 32'hFFF, 32'h5A, 32'h0);
        chk("memFFF", 32'(mem[12'hFFF]), 32'h5A);
        drive(1'b1, F3_B, 32'h1000, 32'h0);
        cyc("sb_oob", 0, 1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        drive(1'b0, F3_W, 32'hFFFFFFFE, 32'h0);
        cyc("lw_wrap", 0, 1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 3'b011, 32'h100, 32'h0);
        cyc("ld_f3_011", 0, 1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        drive(1'b1, F3_BU, 32'h100, 32'h0);
        cyc("st_f3_100", 0, 1, 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0);
        bus.req_valid     = 1'b0;
        bus_ns.req_valid  = 1'b1;
        bus_ns.req_we     = 1'b0;
        bus_ns.req_funct3 = F3_W;
        bus_ns.req_addr   = 32'h102;
        @(negedge clk);
        chk("ns.fault",     32'(bus_ns.fault),     32'd1);
        chk("ns.rsp_valid", 32'(bus_ns.rsp_valid), 32'd1);
        chk("ns.stall",     32'(bus_ns.stall),     32'd0);
        chk("ns.mem_read",  32'(bus_ns.mem_read),  32'd0);
        chk("ns.rsp_rdata", bus_ns.rsp_rdata,      32'd0);
        @(posedge clk);
        #1;
        bus_ns.req_valid = 1'b0;

        // 5: reset after the second byte of a split store
        drive(1'b1, F3_W, 32'h401, 32'hAABBCCDD);
        cyc("sw_r0", 1, 0, 0, 0, 1, F3_B, 32'h401, 32'hDD, 32'h0);
        cyc("sw_r1", 1, 0, 0, 0, 1, F3_B, 32'h402, 32'hCC, 32'h0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        chk("mem401", 32'(mem[12'h401]), 32'hDD);
        chk("mem402", 32'(mem[12'h402]), 32'hCC);
        chk("mem403", 32'(mem[12'h403]), 32'h00);
        chk("mem404", 32'(mem[12'h404]), 32'h00);
        drive(1'b0, F3_W, 32'h400, 32'h0);
        cyc("lw_post_rst", 0, 1, 0, 1, 0, F3_W, 32'h400, 32'h0, 32'h00CCDD00);

        // 6: request withdrawn mid-split
        drive(1'b0, F3_W, 32'h501, 32'h0);
        cyc("lw_ab0", 1, 0, 0, 1, 0, F3_BU, 32'h501, 32'h0, 32'h0);
        cyc("lw_ab1", 1, 0, 0, 1, 0, F3_BU, 32'h502, 32'h0, 32'h0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk);
        #1;
        drive(1'b0, F3_W, 32'h100, 32'h0);
        cyc("lw_after_ab", 0, 1, 0, 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF);
        bus.req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
